softmax_max_buffer: RTL
=======================

Name: softmax_max_buffer

Overview:
- Input stage of the 32-bit softmax pipeline. Sits directly upstream of the exp_2 stage.
- Captures one frame of number_of_data IEEE-754 single-precision scores and finds the frame maximum while the scores are loaded.
- After the last score is captured, replays every stored score in arrival order, each paired with the frame maximum, so the next stage can form x_i - max before exponentiation.

Parameters:
- data_size, 32: width of one floating-point word (IEEE-754 single precision).
- number_of_data, 10: number of scores per frame (≥2).
- cnt_w, $clog2(number_of_data): width of the capture and replay index counters.

Ports:
- clock_i, input, 1: single clock; all state changes on its rising edge.
- reset_n_i, input, 1: synchronous, active-low reset.
- start_i, input, 1: input qualifier. data_i is captured on every rising edge where start_i=1 and the block is in IDLE/LOAD.
- data_i, input, data_size: score word.
- data_valid_o, output, 1: data_o and max_o are valid this cycle.
- data_o, output, data_size: replayed score x_i.
- max_o, output, data_size: frame maximum; held stable for the whole replay.
- last_o, output, 1: high together with data_valid_o on the final replayed word.
- busy_o, output, 1: high in REPLAY. start_i is ignored while busy_o=1.

Behaviour:
- Reset: when reset_n_i=0 at a rising edge, the block returns to IDLE from any state.
  - Counters cleared, max register cleared, buffer contents don't-care.
  - All outputs 0: data_valid_o, last_o, busy_o, data_o, max_o.
  - Reset mid-LOAD or mid-REPLAY abandons the frame; no partial output follows.
- States: IDLE, LOAD, REPLAY.
- IDLE:
  - start_i=1: buf[0]<=data_i, max<=data_i, wr_idx<=1, go to LOAD.
  - start_i=0: stay in IDLE.
- LOAD:
  - start_i=1: buf[wr_idx]<=data_i, max<=fmax(max,data_i), wr_idx++.
  - start_i=0: stall; nothing is captured and no timeout applies.
  - On the edge capturing word number_of_data-1: go to REPLAY, rd_idx<=0.
- REPLAY: one word per cycle, no backpressure.
  - Registered outputs update on each edge: data_valid_o<=1, data_o<=buf[rd_idx], max_o<=max, busy_o<=1, rd_idx++.
  - last_o<=1 when rd_idx=number_of_data-1.
  - The edge after the last word is emitted: data_valid_o, last_o and busy_o go to 0, state goes to IDLE.
  - data_o and max_o hold their last values until the next replay.
- Latency:
  - With start_i held high, captures occur on edges E1..EN (N=number_of_data).
  - The first valid word appears after edge E(N+1).
  - The last valid word, with last_o=1, appears after edge E(2N).
- fmax, pure bit-level comparison with no rounding:
  - Signs differ: the positive operand wins.
  - Both positive: the larger [30:0] as unsigned wins.
  - Both negative: the smaller [30:0] as unsigned wins.
  - Equal values, including +0 vs -0: the existing max is kept.
  - NaN and Inf are not supported; the result is undefined.
- Back-to-back frames:
  - start_i is ignored during REPLAY.
  - The first IDLE cycle with start_i=1 starts a new frame.
  - Minimum gap between frames: one IDLE edge after the final replayed word.
- Storage: number_of_data x data_size register array, written only in IDLE/LOAD and read only in REPLAY.

Test Plan:
- Nominal frame, start_i held high, 10 words loaded: C05060D2, 40A5D0A4, BF3A1674, 401D24F6, BE3BD70A, 3F461F7D, C0350DF4, 40BEEE67, C0A6D2C4, 3F9DF3B6 -> 10 consecutive valid cycles starting at E11; data_o in the same order; max_o=40BEEE67 (5.9666) on all of them; last_o only with 3F9DF3B6; busy_o drops after E21.
- All-negative frame with C0A6D2C4 in slot 0 and BE3BD70A in slot 5 (others more negative) -> max_o=BE3BD70A (-0.1834).
- Signed-zero tie, frame starting with 80000000 then 00000000, all other words negative -> max_o=80000000 (first kept on tie).
- start_i dropped for 3 cycles after word 4 -> no capture during the gap; replay still carries exactly 10 words in order and starts 3 cycles later than nominal.
- reset_n_i=0 for one edge during replay word 5 -> outputs 0 on the next cycle; no further valids; a new 10-word frame then replays correctly.
- start_i kept high through REPLAY, with a second frame following -> words presented during REPLAY are not captured; the second frame's capture begins on the IDLE edge after last_o, and its own max is reported.

Source files
------------

// File: rtl/softmax_max_buffer.sv
// Input stage of the softmax pipeline: buffers one frame of float32 scores while
// tracking the frame maximum, then replays each score paired with that maximum.
module softmax_max_buffer #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int cnt_w          = $clog2(number_of_data)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic [data_size-1:0] data_i,
  output logic                 data_valid_o,
  output logic [data_size-1:0] data_o,
  output logic [data_size-1:0] max_o,
  output logic                 last_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, REPLAY} state_t;

  localparam logic [cnt_w-1:0] LAST_IDX = cnt_w'(number_of_data - 1);

  state_t               state_q, state_d;
  logic [data_size-1:0] mem [number_of_data];
  logic [data_size-1:0] max_q;
  logic [cnt_w-1:0]     wr_idx, rd_idx;
  logic                 capture;

  // Bit-level float compare: true only when cand is strictly greater than cur,
  // so ties (including +0 vs -0) keep the value already held.
  function automatic logic exceeds(input logic [data_size-1:0] cand,
                                   input logic [data_size-1:0] cur);
    logic [data_size-2:0] cand_mag, cur_mag;
    cand_mag = cand[data_size-2:0];
    cur_mag  = cur[data_size-2:0];
    if (cand_mag == '0 && cur_mag == '0)
      return 1'b0;
    if (cand[data_size-1] != cur[data_size-1])
      return ~cand[data_size-1];
    if (!cand[data_size-1])
      return cand_mag > cur_mag;
    return cand_mag < cur_mag;
  endfunction

  assign capture = start_i && (state_q != REPLAY);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (start_i && wr_idx == LAST_IDX) state_d = REPLAY;
      REPLAY:  if (last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (capture)
      mem[(state_q == IDLE) ? '0 : wr_idx] <= data_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      max_q        <= '0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      max_o        <= '0;
      last_o       <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            max_q  <= data_i;
            wr_idx <= cnt_w'(1);
          end
        end
        LOAD: begin
          if (start_i) begin
            if (exceeds(data_i, max_q))
              max_q <= data_i;
            wr_idx <= wr_idx + cnt_w'(1);
            if (wr_idx == LAST_IDX)
              rd_idx <= '0;
          end
        end
        REPLAY: begin
          // last_o marks the final beat already on the outputs; this edge closes the frame.
          if (last_o) begin
            data_valid_o <= 1'b0;
            last_o       <= 1'b0;
            busy_o       <= 1'b0;
            wr_idx       <= '0;
          end else begin
            data_valid_o <= 1'b1;
            data_o       <= mem[rd_idx];
            max_o        <= max_q;
            busy_o       <= 1'b1;
            last_o       <= (rd_idx == LAST_IDX);
            rd_idx       <= rd_idx + cnt_w'(1);
          end
        end
        default: begin
          data_valid_o <= 1'b0;
          last_o       <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
